// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream (ASCII plus CR/LF/BS/FF) into write cycles on the
// character RAM port A, tracking the cursor and blanking each newly entered line or the whole screen.
module text_console_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 14
) (
  input  logic              i_char_write_clock,
  input  logic              i_reset,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_char_write_addr,
  output logic [7:0]        o_char_write_data,
  output logic              o_char_write_enable,
  output logic [6:0]        o_cursor_col,
  output logic [6:0]        o_cursor_row,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLR_LINE, S_CLR_SCREEN} state_t;

  localparam logic [ADDR_W-1:0] L_COLS     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] L_COLS_M1  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] L_TOTAL_M1 = ADDR_W'(COLS * ROWS - 1);
  localparam logic [6:0]        L_LAST_COL = 7'(COLS - 1);
  localparam logic [6:0]        L_LAST_ROW = 7'(ROWS - 1);

  state_t              r_state, w_state;
  logic [6:0]          r_col, w_col, r_row, w_row;
  logic [ADDR_W-1:0]   r_line_base, w_line_base;
  logic [ADDR_W-1:0]   r_addr, w_addr, r_cnt, w_cnt;
  logic [7:0]          r_data, w_data;
  logic                r_we, w_we, r_adv, w_adv;

  logic [ADDR_W-1:0]   w_cur_addr, w_base_inc;
  logic [6:0]          w_row_inc;

  assign w_cur_addr = r_line_base + ADDR_W'(r_col);
  assign w_row_inc  = (r_row == L_LAST_ROW) ? 7'd0 : r_row + 7'd1;
  assign w_base_inc = (r_row == L_LAST_ROW) ? '0 : r_line_base + L_COLS;

  always_comb begin
    w_state     = r_state;
    w_col       = r_col;
    w_row       = r_row;
    w_line_base = r_line_base;
    w_addr      = r_addr;
    w_data      = r_data;
    w_cnt       = r_cnt;
    w_we        = 1'b0;
    w_adv       = r_adv;
    case (r_state)
      S_IDLE: begin
        if (i_in_valid) begin
          if (i_in_data >= 8'h20) begin
            w_state = S_WRITE;
            w_we    = 1'b1;
            w_addr  = w_cur_addr;
            w_data  = i_in_data;
            w_adv   = 1'b1;
          end else begin
            case (i_in_data)
              8'h0D: w_col = 7'd0;
              8'h0A: begin
                w_row       = w_row_inc;
                w_line_base = w_base_inc;
                w_state     = S_CLR_LINE;
                w_we        = 1'b1;
                w_addr      = w_base_inc;
                w_data      = 8'h20;
                w_cnt       = '0;
              end
              8'h08: begin
                // Backspace blanks the cell it moves onto and leaves the cursor there.
                if (r_col != 7'd0) begin
                  w_col   = r_col - 7'd1;
                  w_state = S_WRITE;
                  w_we    = 1'b1;
                  w_addr  = w_cur_addr - ADDR_W'(1);
                  w_data  = 8'h20;
                  w_adv   = 1'b0;
                end
              end
              8'h0C: begin
                w_col       = 7'd0;
                w_row       = 7'd0;
                w_line_base = '0;
                w_state     = S_CLR_SCREEN;
                w_we        = 1'b1;
                w_addr      = '0;
                w_data      = 8'h20;
                w_cnt       = '0;
              end
              default: ;
            endcase
          end
        end
      end
      S_WRITE: begin
        w_state = S_IDLE;
        if (r_adv) begin
          if (r_col == L_LAST_COL) begin
            w_col       = 7'd0;
            w_row       = w_row_inc;
            w_line_base = w_base_inc;
            w_state     = S_CLR_LINE;
            w_we        = 1'b1;
            w_addr      = w_base_inc;
            w_data      = 8'h20;
            w_cnt       = '0;
          end else begin
            w_col = r_col + 7'd1;
          end
        end
      end
      S_CLR_LINE, S_CLR_SCREEN: begin
        if (r_cnt == ((r_state == S_CLR_LINE) ? L_COLS_M1 : L_TOTAL_M1)) begin
          w_state = S_IDLE;
        end else begin
          w_we   = 1'b1;
          w_addr = r_addr + ADDR_W'(1);
          w_cnt  = r_cnt + ADDR_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_char_write_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_col       <= 7'd0;
      r_row       <= 7'd0;
      r_line_base <= '0;
      r_addr      <= '0;
      r_data      <= 8'h00;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_adv       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_col       <= w_col;
      r_row       <= w_row;
      r_line_base <= w_line_base;
      r_addr      <= w_addr;
      r_data      <= w_data;
      r_cnt       <= w_cnt;
      r_we        <= w_we;
      r_adv       <= w_adv;
    end
  end

  assign o_in_ready          = (r_state == S_IDLE) && !i_reset;
  assign o_char_write_addr   = r_addr;
  assign o_char_write_data   = r_data;
  assign o_char_write_enable = r_we;
  assign o_cursor_col        = r_col;
  assign o_cursor_row        = r_row;
  assign o_busy              = (r_state == S_CLR_LINE) || (r_state == S_CLR_SCREEN);

endmodule
